// File: rtl/bin_to_digits_seq.sv
// Sequential binary-to-decimal converter feeding the 4-digit seven-segment stage.
// It uses shift-add-3 (double dabble) at one input bit per clock. Digit outputs
// only update in the FORMAT cycle, so the display never shows a partial result.
module bin_to_digits_seq #(
  parameter int unsigned WIDTH    = 14,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [5:0]       digit3_o,
  output logic [5:0]       digit2_o,
  output logic [5:0]       digit1_o,
  output logic [5:0]       digit0_o
);

  localparam int unsigned CntW     = $clog2(WIDTH + 1);
  localparam logic [5:0]  CodeOff  = 6'd16;
  localparam logic [5:0]  CodeDash = 6'd17;

  typedef enum logic [1:0] {StIdle, StShift, StFormat} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [5:0]        digit3_q, digit3_d, digit2_q, digit2_d;
  logic [5:0]        digit1_q, digit1_d, digit0_q, digit0_d;
  logic [19:0]       bcd_adj;

  // Formatting view of the finished BCD accumulator
  logic [3:0] nib3, nib2, nib1, nib0;
  logic       over, lz3, lz2, lz1;

  assign nib0 = bcd_q[3:0];
  assign nib1 = bcd_q[7:4];
  assign nib2 = bcd_q[11:8];
  assign nib3 = bcd_q[15:12];
  assign over = |bcd_q[19:16];
  // Blanking propagates from the thousands digit down; ones digit never blanks
  assign lz3  = BLANK_LZ && (nib3 == 4'd0);
  assign lz2  = lz3 && (nib2 == 4'd0);
  assign lz1  = lz2 && (nib1 == 4'd0);

  // Next-state logic for the FSM and datapath
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    digit3_d = digit3_q;
    digit2_d = digit2_q;
    digit1_d = digit1_q;
    digit0_d = digit0_q;
    bcd_adj  = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        for (int i = 0; i < 5; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFormat;
      end
      StFormat: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (over) begin
          ovf_d    = 1'b1;
          digit3_d = CodeDash;
          digit2_d = CodeDash;
          digit1_d = CodeDash;
          digit0_d = CodeDash;
        end else begin
          ovf_d    = 1'b0;
          digit3_d = lz3 ? CodeOff : {2'b00, nib3};
          digit2_d = lz2 ? CodeOff : {2'b00, nib2};
          digit1_d = lz1 ? CodeOff : {2'b00, nib1};
          digit0_d = {2'b00, nib0};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      digit3_q <= CodeOff;
      digit2_q <= CodeOff;
      digit1_q <= CodeOff;
      digit0_q <= CodeOff;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      digit3_q <= digit3_d;
      digit2_q <= digit2_d;
      digit1_q <= digit1_d;
      digit0_q <= digit0_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign ovf_o    = ovf_q;
  assign digit3_o = digit3_q;
  assign digit2_o = digit2_q;
  assign digit1_o = digit1_q;
  assign digit0_o = digit0_q;

endmodule
